// File: rtl/lsu_if.sv
// lsu_if: request, data-memory and writeback signals of the load/store unit
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_read;
  logic        req_write;
  logic [4:0]  req_rd;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_err;
  modport slave (
    input  req_valid, req_addr, req_wdata, req_read, req_write, req_rd, mem_ack, mem_rdata, wb_ready,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, wb_err
  );
  modport master (
    output req_valid, req_addr, req_wdata, req_read, req_write, req_rd, mem_ack, mem_rdata, wb_ready,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, wb_err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM with ack timeout.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned requests without a memory access.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [7:0] TO = TIMEOUT[7:0];
  state_t      state, state_d;
  logic [7:0]  cnt;
  logic [31:0] addr_r, wdata_r, wb_data_r;
  logic        we_r, wb_err_r;
  logic [4:0]  rd_r, wb_rd_r;
  logic        go, mis, ack, expire;
  assign go = bus.req_valid && state == IDLE && (bus.req_read || bus.req_write);
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = |bus.req_addr[1:0];
`else
  assign mis = 1'b0;
`endif
  assign ack = state == ACCESS && bus.mem_ack;
  assign expire = state == ACCESS && !bus.mem_ack && cnt == TO;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = go ? (mis ? RESP : ACCESS) : IDLE;
      ACCESS:  state_d = (ack || expire) ? RESP : ACCESS;
      RESP:    state_d = bus.wb_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      we_r      <= 1'b0;
      rd_r      <= '0;
      wb_data_r <= '0;
      wb_rd_r   <= '0;
      wb_err_r  <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        we_r    <= bus.req_write;
        rd_r    <= bus.req_rd;
        cnt     <= 8'd1;
        if (mis) begin
          wb_data_r <= '0;
          wb_err_r  <= 1'b1;
          wb_rd_r   <= bus.req_write ? 5'd0 : bus.req_rd;
        end
      end
      if (ack || expire) begin
        wb_data_r <= (ack && !we_r) ? bus.mem_rdata : 32'd0;
        wb_err_r  <= expire;
        wb_rd_r   <= we_r ? 5'd0 : rd_r;
      end else if (state == ACCESS)
        cnt <= cnt + 8'd1;
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.mem_en    = state == ACCESS;
  assign bus.mem_we    = state == ACCESS && we_r;
  assign bus.mem_addr  = addr_r & 32'hFFFF_FFFC;
  assign bus.mem_wdata = wdata_r;
  assign bus.wb_valid  = state == RESP;
  assign bus.wb_data   = wb_data_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_err    = wb_err_r;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit with TIMEOUT=16
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  lsu_if bus();
  load_store_unit #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_read = r;
    bus.req_write = w;
    bus.req_rd = rd;
    tick;
    bus.req_valid = 1'b0;
  endtask
  task automatic handshake;
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    check("back_to_idle", {31'd0, bus.req_ready}, 32'd1);
  endtask
  initial begin
    bus.req_valid = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_read = 0;
    bus.req_write = 0; bus.req_rd = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.wb_ready = 0;
    tick; tick;
    rst = 1'b0;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
    // minimum-latency read of word 4
    request(32'h10, 32'h0, 1, 0, 5'd3);
    check("rd_mem_en", {31'd0, bus.mem_en}, 32'd1);
    check("rd_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rd_mem_addr", bus.mem_addr, 32'h10);
    check("rd_req_ready", {31'd0, bus.req_ready}, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA500_0004;
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    check("rd_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("rd_wb_data", bus.wb_data, 32'hA500_0004);
    check("rd_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
    check("rd_wb_err", {31'd0, bus.wb_err}, 32'd0);
    check("rd_mem_en_drop", {31'd0, bus.mem_en}, 32'd0);
    handshake;
    check("rd_wb_valid_clr", {31'd0, bus.wb_valid}, 32'd0);
    // no-op request consumed, stray ack in IDLE ignored
    request(32'h30, 32'h0, 0, 0, 5'd9);
    check("noop_ready", {31'd0, bus.req_ready}, 32'd1);
    check("noop_mem_en", {31'd0, bus.mem_en}, 32'd0);
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    check("idle_ack_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("idle_ack_ready", {31'd0, bus.req_ready}, 32'd1);
    // write with 3 wait cycles, mem_addr held 4 cycles
    request(32'h20, 32'hCAFE, 0, 1, 5'd7);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_en && bus.mem_we && bus.mem_addr == 32'h20 && bus.mem_wdata == 32'hCAFE) n++;
      if (i == 3) bus.mem_ack = 1'b1;
      tick;
    end
    bus.mem_ack = 1'b0;
    check("wr_held_cycles", n, 32'd4);
    check("wr_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("wr_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("wr_wb_data", bus.wb_data, 32'd0);
    check("wr_wb_err", {31'd0, bus.wb_err}, 32'd0);
    handshake;
    // read+write treated as write
    request(32'h24, 32'h55, 1, 1, 5'd2);
    check("rw_mem_we", {31'd0, bus.mem_we}, 32'd1);
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    check("rw_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    handshake;
    // timeout without ack
    bus.mem_rdata = 32'h1234_5678;
    request(32'h40, 32'h0, 1, 0, 5'd5);
    n = 0;
    while (bus.mem_en && n < 40) begin
      n++;
      tick;
    end
    check("to_en_cycles", n, 32'd16);
    check("to_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("to_wb_err", {31'd0, bus.wb_err}, 32'd1);
    check("to_wb_data", bus.wb_data, 32'd0);
    check("to_wb_rd", {27'd0, bus.wb_rd}, 32'd5);
    handshake;
    // ack in the 16th cycle wins over timeout
    request(32'h44, 32'h0, 1, 0, 5'd6);
    for (int i = 0; i < 15; i++) tick;
    check("last_en", {31'd0, bus.mem_en}, 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    tick;
    bus.mem_ack = 1'b0;
    check("last_wb_err", {31'd0, bus.wb_err}, 32'd0);
    check("last_wb_data", bus.wb_data, 32'h0BAD_F00D);
    handshake;
    // writeback stall, pending request must wait
    request(32'h50, 32'h0, 1, 0, 5'd11);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_0014;
    tick;
    bus.mem_ack = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 32'h80; bus.req_wdata = 32'h99;
    bus.req_read = 1'b0; bus.req_write = 1'b1; bus.req_rd = 5'd1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.wb_valid && bus.wb_data == 32'h7777_0014 && bus.wb_rd == 5'd11 && !bus.wb_err && !bus.req_ready && !bus.mem_en) n++;
      tick;
    end
    check("stall_stable", n, 32'd5);
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    check("stall_idle", {31'd0, bus.req_ready}, 32'd1);
    check("stall_no_access", {31'd0, bus.mem_en}, 32'd0);
    tick;
    bus.req_valid = 1'b0;
    check("stall_next_en", {31'd0, bus.mem_we}, 32'd1);
    check("stall_next_addr", bus.mem_addr, 32'h80);
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    handshake;
    // reset mid-access, late ack ignored
    request(32'h60, 32'h0, 1, 0, 5'd4);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    tick;
    bus.mem_ack = 1'b0;
    check("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    check("mid_rst_wb_data", bus.wb_data, 32'd0);
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    // misaligned read
    request(32'h13, 32'h0, 1, 0, 5'd8);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("mis_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("mis_wb_err", {31'd0, bus.wb_err}, 32'd1);
    check("mis_wb_data", bus.wb_data, 32'd0);
`else
    check("mis_mem_en", {31'd0, bus.mem_en}, 32'd1);
    check("mis_mem_addr", bus.mem_addr, 32'h10);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA500_0004;
    tick;
    bus.mem_ack = 1'b0;
    check("mis_wb_data", bus.wb_data, 32'hA500_0004);
    check("mis_wb_err", {31'd0, bus.wb_err}, 32'd0);
`endif
    handshake;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles in ACCESS awaiting mem_ack (legal 2..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1; request handshake from execute stage.
REQ-005 SHALL have ports: req_addr in 32, req_wdata in 32, req_read in 1, req_write in 1, req_rd in 5; address (ALU result), store data, access type, destination register.
REQ-006 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32; data-memory request.
REQ-007 SHALL have ports: mem_ack in 1, mem_rdata in 32; memory completion and load data.
REQ-008 SHALL have ports: wb_valid out 1, wb_ready in 1, wb_data out 32, wb_rd out 5, wb_err out 1; response to writeback.

Function
REQ-009 SHALL implement FSM IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL accept a request when req_valid&req_ready; request with req_read=req_write=0 is consumed, FSM stays IDLE, no response.
REQ-011 SHALL treat req_read=req_write=1 as a write.
REQ-012 SHALL on accept register addr/wdata/type/rd and enter ACCESS next cycle.
REQ-013 SHALL in ACCESS hold mem_en=1, mem_we=type, mem_addr={addr[31:2],2'b00}, mem_wdata stable until exit.
REQ-014 SHALL on mem_ack in ACCESS capture mem_rdata (read) or 0 (write) into wb_data, wb_err=0, enter RESP.
REQ-015 SHALL count ACCESS cycles from 1; if count reaches TIMEOUT without mack, enter RESP with wb_data=0, wb_err=1, mem_en dropped.
REQ-016 SHALL give mem_ack priority over timeout when both occur in the same cycle.
REQ-017 SHALL ignore mem_ack in IDLE and RESP.
REQ-018 SHALL in RESP hold wb_valid=1 and wb_data/wb_rd/wb_err stable until wb_ready; then return to IDLE.
REQ-019 SHALL report wb_rd=req_rd for reads and 0 for writes.
REQ-020 SHALL yield minimum latency: accept at edge N, mem_en high after N, ack sampled at N+1, wb_valid high after N+1.
REQ-021 SHALL process one access at a time; no new request accepted before RESP handshake completes.

Reset
REQ-022 SHALL on rst at posedge force IDLE, timeout counter 0, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0.
REQ-023 SHALL on rst mid-ACCESS or mid-RESP drop the outstanding access with no response; late mem_ack ignored.

Configuration
REQ-024 SHALL with LSU_MISALIGN_CHECK_EN defined: request with req_addr[1:0]!=0 bypasses ACCESS (mem_en never asserted), enters RESP next cycle with wb_data=0, wb_err=1.
REQ-025 SHALL without LSU_MISALIGN_CHECK_EN: req_addr[1:0] ignored, access performed at word-aligned address.

Verification
REQ-026 SHALL cover: read addr 0x10, rd=3, memory acks 1 cycle after mem_en -> wb_valid with wb_data=mem word 4, wb_rd=3, wb_err=0, 2 cycles after accept.
REQ-027 SHALL cover: write addr 0x20 data 0xCAFE, ack after 3 wait cycles -> mem_we=1, mem_addr=0x20 held 4 cycles, response wb_rd=0, wb_data=0.
REQ-028 SHALL cover: read, no ack, TIMEOUT=16 -> mem_en high 16 cycles, then wb_err=1, wb_data=0; ack arriving in the 16th cycle -> wb_err=0.
REQ-029 SHALL cover: wb_ready held low 5 cycles in RESP -> wb outputs stable, req_ready=0, new req_valid not accepted until after handshake.
REQ-030 SHALL cover: rst asserted during ACCESS, ack following cycle -> outputs at reset values, no wb_valid.
REQ-031 SHALL cover: addr 0x13 read -> with LSU_MISALIGN_CHECK_EN wb_err=1, mem_en never 1; without it mem_addr=0x10, normal data.
